// File: rtl/iter_shifter.sv
// ----------------------------------------------------------------------------
// iter_shifter
//
// Multi-cycle barrel-free shifter. An accepted request is copied into a
// working register. That register then moves by at most STEP bit positions per
// clock until the requested amount has been applied. Five operations are
// supported: logical left/right, arithmetic right, rotate right and rotate
// left. Any other opcode finishes straight away with a zero result and the
// error flag set.
//
// Ports
//   CLK      in   1      sole clock, rising edge
//   reset    in   1      synchronous, active-low reset
//   start    in   1      request, only looked at while idle
//   flush    in   1      synchronous abort of an in-flight operation
//   op       in   3      000 SLL, 001 SRL, 010 SRA, 011 ROTR, 100 ROTL
//   operand  in   WIDTH  value to shift
//   shamt    in   SHW    shift amount
//   result   out  WIDTH  registered result, held until the next completion
//   done     out  1      one-cycle pulse; result/error valid
//   busy     out  1      high while an operation is running or completing
//   error    out  1      illegal opcode flag, held with result
//
// Timing: if start is accepted on edge E0, done is high in the cycle after
// edge E0+N. N = ceil(shamt/STEP)+1 for legal ops, and N = 1 for illegal ops.
// ----------------------------------------------------------------------------
module iter_shifter #(
  parameter  int WIDTH = 32,               // power of two, 8..64
  parameter  int STEP  = 1,                // 1, 2, 4 or 8 positions per cycle
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_ROTR = 3'b011,
    OP_ROTL = 3'b100
  } op_e;

  // The counter and the per-cycle step are one bit wider than shamt.
  // STEP can equal WIDTH (STEP=8 with WIDTH=8), so it needs the extra bit.
  localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

  state_e           state;
  logic [2:0]       op_q;
  logic             illegal_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW:0]     remaining_q;

  logic [SHW:0]     step_k;
  logic [WIDTH-1:0] work_next;

  // Shift val by k positions (0 < k <= STEP) using the captured operation.
  // SRA refills from the working MSB. That bit never changes during an
  // arithmetic shift, so it always equals the original operand's sign bit.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [2:0]       kind,
    input logic [WIDTH-1:0] val,
    input logic [SHW:0]     k
  );
    logic [WIDTH-1:0] out;
    out = val;
    case (kind)
      OP_SLL:  out = val << k;
      OP_SRL:  out = val >> k;
      OP_SRA:  out = $signed(val) >>> k;
      OP_ROTR: out = (val >> k) | (val << (WIDTH_W - k));
      OP_ROTL: out = (val << k) | (val >> (WIDTH_W - k));
      default: out = val;
    endcase
    return out;
  endfunction

  // NOTE: every signal driven from always_comb gets a value on every path,
  // so no latch can be inferred.
  always_comb begin
    step_k    = (remaining_q < STEP_W) ? remaining_q : STEP_W;
    work_next = shift_by(op_q, work_q, step_k);
  end

  // Single-process FSM with registered outputs. done and busy are loaded
  // together with the next state, so they are exact copies of the state
  // decode and carry no combinational path from the inputs.
  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples pre-edge values no matter what order the statements
  // are in.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      // NOTE: the datapath registers are reset as well as the control
      // registers. This keeps the captured operands in a known state after
      // reset, and it costs nothing because there is no memory array here.
      state       <= S_IDLE;
      op_q        <= '0;
      illegal_q   <= 1'b0;
      work_q      <= '0;
      remaining_q <= '0;
      result      <= '0;
      error       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // flush beats start when both arrive together.
          if (start && !flush) begin
            op_q        <= op;
            illegal_q   <= (op > OP_ROTL);
            work_q      <= operand;
            remaining_q <= {1'b0, shamt};
            state       <= S_RUN;
            busy        <= 1'b1;
          end
        end

        S_RUN: begin
          if (flush) begin
            // Abort: result and error keep whatever the last completion left.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (illegal_q) begin
            state  <= S_DONE;
            result <= '0;
            error  <= 1'b1;
            done   <= 1'b1;
          end else if (remaining_q == '0) begin
            state  <= S_DONE;
            result <= work_q;
            error  <= 1'b0;
            done   <= 1'b1;
          end else begin
            work_q      <= work_next;
            remaining_q <= remaining_q - step_k;
          end
        end

        S_DONE: begin
          // done has already been shown for this cycle. Any start seen now
          // is ignored, because the next state is IDLE without exception.
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// ----------------------------------------------------------------------------
// tb_iter_shifter
//
// Two instances, STEP=1 and STEP=4, share the same stimulus. Each request
// pushes its expected result, error, latency and busy length into one queue
// per instance. The expected values come from a plain arithmetic model of
// each operation. One monitor per instance pops an entry on every done pulse
// and compares it.
// ----------------------------------------------------------------------------
module tb_iter_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int BUDGET = 200;

  logic             clk;
  logic             reset;
  logic             start;
  logic             flush;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] result1, result4;
  logic             done1, done4, busy1, busy4, error1, error4;

  iter_shifter #(.WIDTH(WIDTH), .STEP(1)) u_dut1 (
    .CLK(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .operand(operand), .shamt(shamt), .result(result1), .done(done1),
    .busy(busy1), .error(error1)
  );

  iter_shifter #(.WIDTH(WIDTH), .STEP(4)) u_dut4 (
    .CLK(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .operand(operand), .shamt(shamt), .result(result4), .done(done4),
    .busy(busy4), .error(error4)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    int               n;     // latency N
    int               due;   // cycle count at which done must be seen
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bcnt1    = 0;
  int bcnt4    = 0;

  logic [WIDTH-1:0] last_res = '0;
  logic             last_err = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s at cycle %0d", name, why, cyc);
  endtask

  // Reference model: {error, result} from the operation's definition.
  function automatic logic [WIDTH:0] ref_model(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                               input int s);
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] sext;
    logic [WIDTH-1:0]   r;
    logic               e;
    dbl  = {a, a};
    sext = {{WIDTH{a[WIDTH-1]}}, a};
    e    = 1'b0;
    r    = '0;
    case (o)
      3'd0: r = a << s;
      3'd1: r = a >> s;
      3'd2: begin sext = sext >> s; r = sext[WIDTH-1:0]; end
      3'd3: begin dbl = dbl >> s; r = dbl[WIDTH-1:0]; end
      3'd4: begin dbl = dbl << s; r = dbl[2*WIDTH-1:WIDTH]; end
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  function automatic int n_of(input logic [2:0] o, input int s, input int step);
    if (o > 3'd4) return 1;
    return (s + step - 1) / step + 1;
  endfunction

  // Monitors: count RUN cycles (busy without done) and compare on each done.
  always @(negedge clk) begin
    if (reset) begin
      if (busy1 && !done1) bcnt1++;
      else if (!busy1) bcnt1 = 0;
      if (done1) begin
        if (q1.size() == 0) fail_now("dut1_done", "unexpected done pulse");
        else begin
          e1 = q1.pop_front();
          check("dut1_result", result1, e1.res);
          check("dut1_error", error1, e1.err);
          check("dut1_latency", cyc, e1.due);
          check("dut1_busy_cycles", bcnt1, e1.n);
          check("dut1_busy_at_done", busy1, 1);
        end
        bcnt1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (busy4 && !done4) bcnt4++;
      else if (!busy4) bcnt4 = 0;
      if (done4) begin
        if (q4.size() == 0) fail_now("dut4_done", "unexpected done pulse");
        else begin
          e4 = q4.pop_front();
          check("dut4_result", result4, e4.res);
          check("dut4_error", error4, e4.err);
          check("dut4_latency", cyc, e4.due);
          check("dut4_busy_cycles", bcnt4, e4.n);
          check("dut4_busy_at_done", busy4, 1);
        end
        bcnt4 = 0;
      end
    end
  end

  // Push the expected completion for a request accepted on the edge just passed.
  task automatic push_expected(input logic [2:0] o, input logic [WIDTH-1:0] a, input int s);
    exp_t        e;
    logic [WIDTH:0] m;
    m     = ref_model(o, a, s);
    e.res = m[WIDTH-1:0];
    e.err = m[WIDTH];
    e.n   = n_of(o, s, 1);
    e.due = cyc + e.n;
    q1.push_back(e);
    e.n   = n_of(o, s, 4);
    e.due = cyc + e.n;
    q4.push_back(e);
    last_res = m[WIDTH-1:0];
    last_err = m[WIDTH];
  endtask

  // Wait for both queues to drain, then step to a negedge inside IDLE.
  task automatic wait_idle();
    int t;
    t = 0;
    while ((q1.size() != 0 || q4.size() != 0) && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) begin
      fail_now("timeout", "done not seen within cycle budget");
      q1.delete();
      q4.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge while both instances are idle. With hold set, start
  // stays high and the inputs change for two more RUN edges; the captured
  // request must not be affected. Only use hold when shamt >= 9.
  task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a, input int s,
                        input bit hold);
    op      = o;
    operand = a;
    shamt   = SHW'(s);
    start   = 1'b1;
    @(posedge clk);
    #1;
    push_expected(o, a, s);
    if (hold) begin
      op      = 3'($urandom);
      operand = $urandom;
      shamt   = SHW'($urandom);
      repeat (2) @(posedge clk);
      #1;
    end
    start   = 1'b0;
    op      = 3'($urandom);
    operand = $urandom;
    shamt   = SHW'($urandom);
    wait_idle();
  endtask

  // A start raised only during the DONE cycle must not be accepted.
  task automatic start_in_done();
    op      = 3'd0;
    operand = $urandom;
    shamt   = '0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    push_expected(3'd0, operand, 0);
    start = 1'b0;
    @(negedge clk);              // RUN
    @(negedge clk);              // DONE
    op      = 3'd1;
    operand = $urandom;
    shamt   = 5'd3;
    start   = 1'b1;
    @(negedge clk);              // IDLE
    start = 1'b0;
    check("done_cycle_start_ignored_dut1", busy1, 0);
    check("done_cycle_start_ignored_dut4", busy4, 0);
    wait_idle();
  endtask

  // When flush and start arrive together in IDLE, flush wins.
  task automatic flush_with_start();
    op      = 3'd0;
    operand = $urandom;
    shamt   = 5'd4;
    start   = 1'b1;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_idle_dut1", busy1, 0);
    check("flush_start_idle_dut4", busy4, 0);
    repeat (8) @(negedge clk);
  endtask

  // SLL with shamt=20, aborted by reset or flush on the 5th RUN edge.
  task automatic abort_op(input bit use_reset);
    logic [WIDTH-1:0] xr;
    logic             xe;
    op      = 3'd0;
    operand = $urandom | 32'h1;
    shamt   = 5'd20;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (use_reset) reset = 1'b0;
    else           flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b0;
    xr = use_reset ? '0 : last_res;
    xe = use_reset ? 1'b0 : last_err;
    check(use_reset ? "abort_rst_result1" : "abort_fl_result1", result1, xr);
    check(use_reset ? "abort_rst_result4" : "abort_fl_result4", result4, xr);
    check(use_reset ? "abort_rst_error1" : "abort_fl_error1", error1, xe);
    check(use_reset ? "abort_rst_error4" : "abort_fl_error4", error4, xe);
    check("abort_busy1", busy1, 0);
    check("abort_busy4", busy4, 0);
    check("abort_done1", done1, 0);
    check("abort_done4", done4, 0);
    if (use_reset) begin
      last_res = '0;
      last_err = 1'b0;
    end
    // Any late done pulse would be caught by the monitors here.
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int        s;
    logic [2:0] o;
    reset   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    op      = '0;
    operand = '0;
    shamt   = '0;
    repeat (3) @(negedge clk);
    check("reset_result1", result1, 0);
    check("reset_result4", result4, 0);
    check("reset_done1", done1, 0);
    check("reset_done4", done4, 0);
    check("reset_busy1", busy1, 0);
    check("reset_busy4", busy4, 0);
    check("reset_error1", error1, 0);
    check("reset_error4", error4, 0);

    // Release reset and request in the same cycle: first IDLE edge accepts.
    reset = 1'b1;
    run_op(3'd0, 32'h0000_0001, 1, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF8, 2, 1'b0);
    run_op(3'd1, 32'hFFFF_FFF8, 2, 1'b0);
    run_op(3'd1, 32'h8000_0000, 31, 1'b1);
    run_op(3'd3, 32'h0000_0001, 1, 1'b0);
    run_op(3'd4, 32'h8000_0000, 1, 1'b0);
    run_op(3'd7, 32'h1234_5678, 0, 1'b0);
    run_op(3'd0, 32'h0000_0001, 0, 1'b0);
    run_op(3'd6, 32'hDEAD_BEEF, 31, 1'b0);
    run_op(3'd2, 32'h8000_0000, 31, 1'b0);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      s = $urandom_range(0, 31);
      run_op(o, $urandom, s, (s >= 9) && ($urandom_range(0, 1) == 1));
    end

    start_in_done();
    flush_with_start();

    // Leave error set so the flush abort has to keep it.
    run_op(3'd5, 32'hCAFE_F00D, 7, 1'b0);
    abort_op(1'b0);
    run_op(3'd3, 32'h0F0F_00FF, 9, 1'b0);
    abort_op(1'b1);
    run_op(3'd4, $urandom, $urandom_range(0, 31), 1'b0);

    check("q1_drained", q1.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
